// File: rtl/sys_arbiter.sv
// sys_arbiter: arbitrates the IFU (m0, read-only) and the LSU (m1, read and
// write) onto one shared memory/MMIO slave. One transaction is in flight at a
// time, and choosing the next one always costs a single IDLE cycle.
// Default build: fixed priority, m1 write > m1 read > m0 read.
// Define ARB_ROUND_ROBIN_EN to alternate between m0 and m1 instead
// (m1 write still beats m1 read).
module sys_arbiter (
  input  logic        clk,
  input  logic        rst,
  // IFU read port
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  // LSU read port
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  // LSU write port
  input  logic [31:0] m1_awaddr,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  // Shared slave port
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

  state_t state_q, state_d;
  // grant: 0 = m0 (IFU), 1 = m1 (LSU)
  logic   grant_q, grant_d;
  logic   pick_m1;
  logic   rd_done, wr_done;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = m1 wins a tie between the masters on the next arbitration
  logic   prefer_m1_q;
`endif

  // State and grant registers; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer flips to the other master each time a transaction is started
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefer_m1_q <= 1'b1;
    end else if ((state_q == IDLE) && (state_d != IDLE)) begin
      prefer_m1_q <= ~grant_d;
    end
  end
`endif

  // Decide whether the LSU wins the IDLE-cycle arbitration
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_m1 = (m1_awvalid || m1_arvalid) && (!m0_arvalid || prefer_m1_q);
`else
    pick_m1 = m1_awvalid || m1_arvalid;
`endif
  end

  // Next state and grant: choose only in IDLE, hold the grant until the last handshake
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rd_done = s_rvalid && (grant_q ? m1_rready : m0_rready);
    wr_done = s_bvalid && m1_bready;
    case (state_q)
      IDLE: begin
        if (pick_m1) begin
          grant_d = 1'b1;
          state_d = m1_awvalid ? WR1 : RD1;
        end else if (m0_arvalid) begin
          grant_d = 1'b0;
          state_d = RD0;
        end
      end
      RD0, RD1: begin
        if (rd_done) begin
          state_d = IDLE;
        end
      end
      WR1: begin
        if (wr_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel steering: everything quiet unless a granted transaction is open
  always_comb begin
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    case (state_q)
      RD0, RD1: begin
        if (grant_q) begin
          s_araddr   = m1_araddr;
          s_arvalid  = m1_arvalid;
          s_rready   = m1_rready;
          m1_arready = s_arready;
          m1_rdata   = s_rdata;
          m1_rresp   = s_rresp;
          m1_rvalid  = s_rvalid;
        end else begin
          s_araddr   = m0_araddr;
          s_arvalid  = m0_arvalid;
          s_rready   = m0_rready;
          m0_arready = s_arready;
          m0_rdata   = s_rdata;
          m0_rresp   = s_rresp;
          m0_rvalid  = s_rvalid;
        end
      end
      WR1: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid;
        s_bready   = m1_bready;
        m1_awready = s_awready;
        m1_wready  = s_wready;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sys_arbiter.sv
// tb_sys_arbiter: random masters and a random-latency slave drive sys_arbiter;
// a transaction-level model predicts which request is being served each cycle
// and what every port must show. Compile with ARB_ROUND_ROBIN_EN to match the
// round-robin build.
module tb_sys_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m0_rdata, m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [1:0]  m0_rresp, m1_rresp, m1_bresp, s_rresp, s_bresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [3:0]  m1_wstrb, s_wstrb;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

  sys_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  // Which request the arbiter is currently serving, in transaction terms
  typedef enum int {OWN_NONE, OWN_M0R, OWN_M1R, OWN_M1W} owner_t;

  int tests_run    = 0;
  int tests_failed = 0;

  owner_t      model_owner;
  bit          model_last_m1;
  owner_t      done_q[$];
  int          issued_total, served_total;

  bit          m0_pend, m0_ar_done, m1r_pend, m1r_ar_done;
  bit          m1w_pend, m1w_aw_done, m1w_w_done;
  logic [31:0] m0_addr, m1r_addr, m1w_addr, m1w_data;
  logic [3:0]  m1w_strb;

  bit          sl_rd_busy, sl_aw_got, sl_w_got;
  int          sl_rd_lat, sl_b_lat;
  logic [31:0] sl_rdata;
  logic [1:0]  sl_rresp, sl_bresp;

  int          req_pct;
  bit          fix_rd_en, staged_w, fix_bresp_en;
  int          fix_rd_lat;
  logic [31:0] fix_rdata;
  logic [1:0]  fix_rresp, fix_bresp;

  logic [31:0] last_m0_rdata, last_s_awaddr, last_s_wdata;
  logic [1:0]  last_m0_rresp, last_bresp;
  logic [3:0]  last_s_wstrb;
  int          s_aw_hs_cnt, s_w_hs_cnt;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit isM1(input owner_t o);
    return (o == OWN_M1R) || (o == OWN_M1W);
  endfunction

  function automatic logic [255:0] allOutputs();
    logic [255:0] v;
    v = '0;
    v[181:0] = {m0_arready, m0_rdata, m0_rresp, m0_rvalid,
                m1_arready, m1_rdata, m1_rresp, m1_rvalid,
                m1_awready, m1_wready, m1_bresp, m1_bvalid,
                s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid,
                s_wdata, s_wstrb, s_wvalid, s_bready};
    return v;
  endfunction

  task automatic raiseM0(input logic [31:0] a);
    m0_pend = 1'b1; m0_ar_done = 1'b0; m0_addr = a; issued_total++;
  endtask

  task automatic raiseM1R(input logic [31:0] a);
    m1r_pend = 1'b1; m1r_ar_done = 1'b0; m1r_addr = a; issued_total++;
  endtask

  task automatic raiseM1W(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m1w_pend = 1'b1; m1w_aw_done = 1'b0; m1w_w_done = 1'b0;
    m1w_addr = a; m1w_data = d; m1w_strb = s; issued_total++;
  endtask

  // Forget every open transaction and park all inputs at 0
  task automatic clearAll();
    m0_pend = 0; m0_ar_done = 0; m1r_pend = 0; m1r_ar_done = 0;
    m1w_pend = 0; m1w_aw_done = 0; m1w_w_done = 0;
    sl_rd_busy = 0; sl_aw_got = 0; sl_w_got = 0; sl_rd_lat = 0; sl_b_lat = 0;
    model_owner = OWN_NONE; model_last_m1 = 1'b0;
    m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
    m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
  endtask

  // What each port must show this cycle given the transaction being served
  task automatic checkForwarding();
    case (model_owner)
      OWN_NONE: checkOutput("idle_quiet", 256'({m0_arready, m0_rvalid, m1_arready, m1_rvalid,
                            m1_awready, m1_wready, m1_bvalid, s_arvalid, s_rready,
                            s_awvalid, s_wvalid, s_bready}), '0);
      OWN_M0R: begin
        checkOutput("m0_r_path", 256'({m0_arready, m0_rvalid, m0_rdata, m0_rresp}),
                    256'({s_arready, s_rvalid, s_rdata, s_rresp}));
        checkOutput("s_ar_from_m0", 256'({s_arvalid, s_araddr, s_rready}),
                    256'({m0_arvalid, m0_araddr, m0_rready}));
        checkOutput("m1_quiet", 256'({m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}), '0);
        checkOutput("s_wr_quiet", 256'({s_awvalid, s_wvalid, s_bready}), '0);
      end
      OWN_M1R: begin
        checkOutput("m1_r_path", 256'({m1_arready, m1_rvalid, m1_rdata, m1_rresp}),
                    256'({s_arready, s_rvalid, s_rdata, s_rresp}));
        checkOutput("s_ar_from_m1", 256'({s_arvalid, s_araddr, s_rready}),
                    256'({m1_arvalid, m1_araddr, m1_rready}));
        checkOutput("m0_quiet", 256'({m0_arready, m0_rvalid, m1_awready, m1_wready, m1_bvalid}), '0);
        checkOutput("s_wr_quiet", 256'({s_awvalid, s_wvalid, s_bready}), '0);
      end
      default: begin
        checkOutput("m1_b_path", 256'({m1_awready, m1_wready, m1_bvalid, m1_bresp}),
                    256'({s_awready, s_wready, s_bvalid, s_bresp}));
        checkOutput("s_w_from_m1", 256'({s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready}),
                    256'({m1_awvalid, m1_awaddr, m1_wvalid, m1_wdata, m1_wstrb, m1_bready}));
        checkOutput("rd_quiet", 256'({m0_arready, m0_rvalid, m1_arready, m1_rvalid, s_arvalid, s_rready}), '0);
      end
    endcase
  endtask

  // One clock: drive masters and slave, check, then account for handshakes
  task automatic applyStimulus();
    bit both_before, want_m1, pick_m1;
    @(negedge clk);
    if (!m0_pend && ($urandom_range(99) < req_pct)) raiseM0($urandom);
    if (!m1r_pend && ($urandom_range(99) < req_pct)) raiseM1R($urandom);
    if (!m1w_pend && ($urandom_range(99) < req_pct)) raiseM1W($urandom, $urandom, 4'($urandom));
    m0_arvalid = m0_pend && !m0_ar_done;
    m0_araddr  = m0_arvalid ? m0_addr : $urandom;
    m0_rready  = ($urandom_range(3) != 0);
    m1_arvalid = m1r_pend && !m1r_ar_done;
    m1_araddr  = m1_arvalid ? m1r_addr : $urandom;
    m1_rready  = ($urandom_range(3) != 0);
    m1_awvalid = m1w_pend && !m1w_aw_done;
    m1_awaddr  = m1_awvalid ? m1w_addr : $urandom;
    m1_wvalid  = m1w_pend && !m1w_w_done;
    m1_wdata   = m1_wvalid ? m1w_data : $urandom;
    m1_wstrb   = m1_wvalid ? m1w_strb : 4'($urandom);
    m1_bready  = ($urandom_range(3) != 0);
    s_arready  = !sl_rd_busy && ($urandom_range(3) != 0);
    s_rvalid   = sl_rd_busy && (sl_rd_lat == 0);
    s_rdata    = s_rvalid ? sl_rdata : $urandom;
    s_rresp    = s_rvalid ? sl_rresp : 2'($urandom_range(3));
    if (staged_w) begin
      s_awready = !sl_aw_got;
      s_wready  = sl_aw_got && !sl_w_got;
    end else begin
      s_awready = !sl_aw_got && ($urandom_range(1) == 1);
      s_wready  = !sl_w_got && ($urandom_range(1) == 1);
    end
    s_bvalid = sl_aw_got && sl_w_got && (sl_b_lat == 0);
    s_bresp  = s_bvalid ? sl_bresp : 2'($urandom_range(3));
    #1;
    checkForwarding();

    if (m0_arvalid && m0_arready) m0_ar_done = 1'b1;
    if (m0_rvalid && m0_rready && m0_pend) begin
      checkOutput("m0_rdata", 256'({m0_rdata, m0_rresp}), 256'({sl_rdata, sl_rresp}));
      last_m0_rdata = m0_rdata; last_m0_rresp = m0_rresp;
      m0_pend = 1'b0; served_total++; done_q.push_back(OWN_M0R);
    end
    if (m1_arvalid && m1_arready) m1r_ar_done = 1'b1;
    if (m1_rvalid && m1_rready && m1r_pend) begin
      checkOutput("m1_rdata", 256'({m1_rdata, m1_rresp}), 256'({sl_rdata, sl_rresp}));
      m1r_pend = 1'b0; served_total++; done_q.push_back(OWN_M1R);
    end
    if (m1_awvalid && m1_awready) m1w_aw_done = 1'b1;
    if (m1_wvalid && m1_wready) m1w_w_done = 1'b1;
    if (m1_bvalid && m1_bready && m1w_pend) begin
      checkOutput("m1_bresp", 256'(m1_bresp), 256'(sl_bresp));
      last_bresp = m1_bresp;
      m1w_pend = 1'b0; served_total++; done_q.push_back(OWN_M1W);
    end

    if (s_arvalid && s_arready) begin
      checkOutput("s_araddr_hs", 256'(s_araddr), 256'((model_owner == OWN_M1R) ? m1r_addr : m0_addr));
      sl_rd_busy = 1'b1;
      sl_rd_lat  = fix_rd_en ? fix_rd_lat : int'($urandom_range(3));
      sl_rdata   = fix_rd_en ? fix_rdata : $urandom;
      sl_rresp   = fix_rd_en ? fix_rresp : 2'($urandom_range(3));
    end else if (s_rvalid && s_rready) begin
      sl_rd_busy = 1'b0;
    end else if (sl_rd_busy && (sl_rd_lat > 0)) begin
      sl_rd_lat--;
    end
    both_before = sl_aw_got && sl_w_got;
    if (s_awvalid && s_awready) begin
      checkOutput("s_awaddr_hs", 256'(s_awaddr), 256'(m1w_addr));
      last_s_awaddr = s_awaddr; sl_aw_got = 1'b1; s_aw_hs_cnt++;
    end
    if (s_wvalid && s_wready) begin
      checkOutput("s_wdata_hs", 256'({s_wdata, s_wstrb}), 256'({m1w_data, m1w_strb}));
      last_s_wdata = s_wdata; last_s_wstrb = s_wstrb; sl_w_got = 1'b1; s_w_hs_cnt++;
    end
    if (s_bvalid && s_bready) begin
      sl_aw_got = 1'b0; sl_w_got = 1'b0;
    end else if (!both_before && sl_aw_got && sl_w_got) begin
      sl_b_lat = int'($urandom_range(2));
      sl_bresp = fix_bresp_en ? fix_bresp : 2'($urandom_range(3));
    end else if (both_before && (sl_b_lat > 0)) begin
      sl_b_lat--;
    end

    // Transaction model: one request served at a time, one IDLE cycle to choose
    case (model_owner)
      OWN_NONE: begin
        want_m1 = m1_awvalid || m1_arvalid;
`ifdef ARB_ROUND_ROBIN_EN
        pick_m1 = want_m1 && (!m0_arvalid || !model_last_m1);
`else
        pick_m1 = want_m1;
`endif
        if (pick_m1) begin
          model_owner = m1_awvalid ? OWN_M1W : OWN_M1R;
          model_last_m1 = 1'b1;
        end else if (m0_arvalid) begin
          model_owner = OWN_M0R;
          model_last_m1 = 1'b0;
        end
      end
      OWN_M0R: if (s_rvalid && m0_rready) model_owner = OWN_NONE;
      OWN_M1R: if (s_rvalid && m1_rready) model_owner = OWN_NONE;
      default: if (s_bvalid && m1_bready) model_owner = OWN_NONE;
    endcase
  endtask

  task automatic drain();
    int n;
    req_pct = 0;
    n = 0;
    while ((m0_pend || m1r_pend || m1w_pend || sl_rd_busy || sl_aw_got || sl_w_got ||
            (model_owner != OWN_NONE)) && (n < 400)) begin
      applyStimulus();
      n++;
    end
    if (n >= 400) checkOutput("drain_timeout", 256'(n), 256'(0));
    applyStimulus();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit exp_m1;
    issued_total = 0; served_total = 0;
    req_pct = 0; fix_rd_en = 0; staged_w = 0; fix_bresp_en = 0;
    fix_rd_lat = 0; fix_rdata = '0; fix_rresp = '0; fix_bresp = '0;
    s_aw_hs_cnt = 0; s_w_hs_cnt = 0;
    clearAll();
    rst = 1'b1;
    #1;
    checkOutput("reset_outputs", allOutputs(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // IFU read alone, slave answers 0xDEAD_BEEF after a fixed delay
    fix_rd_en = 1; fix_rd_lat = 3; fix_rdata = 32'hDEAD_BEEF; fix_rresp = 2'b00;
    done_q.delete();
    raiseM0(32'h0000_0100);
    drain();
    checkOutput("d1_rdata", 256'({last_m0_rdata, last_m0_rresp}), 256'({32'hDEAD_BEEF, 2'b00}));
    checkOutput("d1_order", 256'({done_q.size(), int'(done_q[0])}), 256'({32'd1, int'(OWN_M0R)}));
    fix_rd_en = 0;

    // Warm-up write leaves the last grant with m1, then m0 read and m1 write collide
    raiseM1W(32'h0000_3000, 32'h0, 4'h1);
    drain();
    done_q.delete();
    raiseM0(32'h0000_0200);
    raiseM1W(32'h0000_2000, 32'h1234_5678, 4'b1111);
    drain();
`ifdef ARB_ROUND_ROBIN_EN
    checkOutput("d2_order", 256'({int'(done_q[0]), int'(done_q[1])}), 256'({int'(OWN_M0R), int'(OWN_M1W)}));
`else
    checkOutput("d2_order", 256'({int'(done_q[0]), int'(done_q[1])}), 256'({int'(OWN_M1W), int'(OWN_M0R)}));
`endif
    checkOutput("d2_write", 256'({last_s_awaddr, last_s_wdata, last_s_wstrb}),
                256'({32'h0000_2000, 32'h1234_5678, 4'b1111}));

    // Write whose address is accepted one cycle before its data
    staged_w = 1; fix_bresp_en = 1; fix_bresp = 2'b10;
    s_aw_hs_cnt = 0; s_w_hs_cnt = 0;
    raiseM1W(32'h0000_4000, 32'hCAFE_F00D, 4'b0100);
    drain();
    checkOutput("d4_bresp", 256'(last_bresp), 256'(2'b10));
    checkOutput("d4_single", 256'({s_aw_hs_cnt, s_w_hs_cnt, last_s_wstrb}), 256'({32'd1, 32'd1, 4'b0100}));
    staged_w = 0; fix_bresp_en = 0;

    // Reset while an LSU read waits for its data
    fix_rd_en = 1; fix_rd_lat = 8; fix_rdata = 32'h5555_AAAA; fix_rresp = 2'b01;
    done_q.delete();
    raiseM1R(32'h0000_0800);
    n = 0;
    while (!((model_owner == OWN_M1R) && sl_rd_busy) && (n < 30)) begin
      applyStimulus();
      n++;
    end
    checkOutput("d5_reach_rd1", 256'(n < 30), 256'(1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("d5_rst_outputs", allOutputs(), '0);
    issued_total = issued_total - int'(m0_pend) - int'(m1r_pend) - int'(m1w_pend);
    clearAll();
    @(negedge clk);
    #1;
    checkOutput("d5_rst_hold", allOutputs(), '0);
    @(negedge clk);
    rst = 1'b0;
    fix_rd_en = 0;
    raiseM0(32'h0000_0040);
    drain();
    checkOutput("d5_after_rst", 256'({done_q.size(), int'(done_q[0])}), 256'({32'd1, int'(OWN_M0R)}));

    // Random traffic, light then heavy
    req_pct = 30;
    for (int i = 0; i < 500; i++) applyStimulus();
    req_pct = 80;
    for (int i = 0; i < 300; i++) applyStimulus();
    drain();

    // Both masters requesting without pause
    done_q.delete();
    req_pct = 100;
    n = 0;
    while ((done_q.size() < 10) && (n < 600)) begin
      applyStimulus();
      n++;
    end
    checkOutput("d6_count", 256'(done_q.size() >= 10), 256'(1));
    for (int i = 1; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_m1 = !isM1(done_q[i-1]);
`else
      exp_m1 = 1'b1;
`endif
      checkOutput("d6_grant_seq", 256'(isM1(done_q[i])), 256'(exp_m1));
    end
    drain();

    checkOutput("all_served", 256'(served_total), 256'(issued_total));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
